// File: rtl/csa_mult_pkg.sv
// csa_mult_pkg: sizing helpers shared by the pipelined carry-save multiplier.
// Per-stage row count and product width are derived here from WIDTH/STAGES.
package csa_mult_pkg;

    function automatic int rows_per_stage(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/csa_row.sv
// csa_row: one row of full adders folding a partial-product vector into sum/carry.
// The carry output is pre-shifted so the next row consumes it directly.
module csa_row #(
    parameter int PW = 32
) (
    input  logic [PW-1:0] pp_i,
    input  logic [PW-1:0] sum_i,
    input  logic [PW-1:0] carry_i,
    output logic [PW-1:0] sum_o,
    output logic [PW-1:0] carry_o
);

    logic [PW-1:0] maj;

    assign sum_o   = pp_i ^ sum_i ^ carry_i;
    assign maj     = (pp_i & sum_i) | (pp_i & carry_i) | (sum_i & carry_i);
    assign carry_o = maj << 1;

endmodule

// File: rtl/csa_mult_pipe.sv
// csa_mult_pipe: pipelined signed/unsigned carry-save array multiplier.
// Define CSA_MULT_CHECK_EN to add a reference product path and chk_err output.
module csa_mult_pipe
    import csa_mult_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic                  in_signed,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    out_p,
    output logic [TAG_W-1:0]      out_tag
`ifdef CSA_MULT_CHECK_EN
    ,
    output logic                  chk_err
`endif
);

    localparam int PW  = prod_width(WIDTH);
    localparam int RPS = rows_per_stage(WIDTH, STAGES);

    typedef struct packed {
        logic             valid;
        logic [PW-1:0]    sum;
        logic [PW-1:0]    carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             signed_mode;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // Baugh-Wooley: invert cross terms with exactly one sign bit, add 2^W and 2^(2W-1).
    function automatic logic [PW-1:0] pp_row(
        input logic [WIDTH-1:0] a,
        input logic             bi,
        input int               i,
        input logic             sm
    );
        logic [PW-1:0] v;
        logic          bv;
        v = '0;
        for (int j = 0; j < WIDTH; j++) begin
            bv = a[j] & bi;
            if (sm && ((j == WIDTH-1) != (i == WIDTH-1)))
                bv = ~bv;
            v[i+j] = bv;
        end
        if (sm && i == 0) begin
            v[WIDTH]  = 1'b1;
            v[PW-1]   = 1'b1;
        end
        return v;
    endfunction

    stage_t [STAGES-1:0] src;
    stage_t [STAGES-1:0] st_d;
    stage_t [STAGES-1:0] st_q;
    stage_t              last;

    logic                advance;
    logic                out_valid_q;
    logic [PW-1:0]       out_p_q;
    logic [PW-1:0]       out_p_d;
    logic [TAG_W-1:0]    out_tag_q;
    logic                unused_last;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [PW-1:0] s_w [RPS+1];
        logic [PW-1:0] c_w [RPS+1];

        if (k == 0) begin : g_src0
            assign src[k] = '{valid: in_valid, sum: '0, carry: '0,
                              a: in_a, b: in_b,
                              signed_mode: in_signed, tag: in_tag};
        end else begin : g_srcn
            assign src[k] = st_q[k-1];
        end

        assign s_w[0] = src[k].sum;
        assign c_w[0] = src[k].carry;

        for (genvar r = 0; r < RPS; r++) begin : g_row
            if (k*RPS + r < WIDTH) begin : g_add
                logic [PW-1:0] pp;
                assign pp = pp_row(src[k].a, src[k].b[k*RPS+r],
                                   k*RPS + r, src[k].signed_mode);
                csa_row #(.PW(PW)) u_row (
                    .pp_i    (pp),
                    .sum_i   (s_w[r]),
                    .carry_i (c_w[r]),
                    .sum_o   (s_w[r+1]),
                    .carry_o (c_w[r+1])
                );
            end else begin : g_pass
                assign s_w[r+1] = s_w[r];
                assign c_w[r+1] = c_w[r];
            end
        end

        assign st_d[k] = '{valid: src[k].valid,
                           sum: s_w[RPS], carry: c_w[RPS],
                           a: src[k].a, b: src[k].b,
                           signed_mode: src[k].signed_mode,
                           tag: src[k].tag};
    end

    assign last        = st_q[STAGES-1];
    assign out_p_d     = last.sum + last.carry;
    assign unused_last = ^{last.a, last.b, last.signed_mode};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_tag_q   <= '0;
        end else if (advance) begin
            st_q        <= st_d;
            out_valid_q <= last.valid;
            out_p_q     <= out_p_d;
            out_tag_q   <= last.tag;
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_tag   = out_tag_q;

`ifdef CSA_MULT_CHECK_EN
    // Two's-complement product mod 2^PW equals the product of sign-extended operands.
    logic [PW-1:0]           ext_a;
    logic [PW-1:0]           ext_b;
    logic [PW-1:0]           ref_d;
    logic [STAGES:0][PW-1:0] ref_q;

    assign ext_a = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a}
                             : {{WIDTH{1'b0}}, in_a};
    assign ext_b = in_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b}
                             : {{WIDTH{1'b0}}, in_b};
    assign ref_d = ext_a * ext_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
        end else if (advance) begin
            ref_q <= {ref_q[STAGES-1:0], ref_d};
        end
    end

    assign chk_err = out_valid_q && out_ready && (out_p_q != ref_q[STAGES]);
`endif

endmodule

// File: tb/tb_csa_mult_pipe.sv
// tb_csa_mult_pipe: directed and streamed checks of csa_mult_pipe against
// a slot-level behavioural model with arithmetic reference products.
module tb_csa_mult_pipe;

    localparam int W   = 16;
    localparam int S   = 4;
    localparam int TW  = 4;
    localparam int PW  = 2 * W;
    localparam int LAT = S + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_signed = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_p;
    logic [TW-1:0] out_tag;
`ifdef CSA_MULT_CHECK_EN
    logic          chk_err;
`endif

    int checks = 0;
    int failures = 0;
    int recv = 0;
    bit rnd = 1'b0;

    csa_mult_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
`ifdef CSA_MULT_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s);
        longint x, y, p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[PW-1:0];
    endfunction

    // Model: LAT result slots that shift whenever the output is free.
    logic          mv [LAT];
    logic [PW-1:0] mp [LAT];
    logic [TW-1:0] mt [LAT];
    logic          m_adv;

    assign m_adv = !mv[LAT-1] || out_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) mv[i] <= 1'b0;
        end else if (m_adv) begin
            for (int i = LAT-1; i > 0; i--) begin
                mv[i] <= mv[i-1];
                mp[i] <= mp[i-1];
                mt[i] <= mt[i-1];
            end
            mv[0] <= in_valid;
            mp[0] <= ref_prod(in_a, in_b, in_signed);
            mt[0] <= in_tag;
        end
    end

    logic          stall_prev = 1'b0;
    logic [PW-1:0] held_p;
    logic [TW-1:0] held_t;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, mv[LAT-1]);
            chk("in_ready", in_ready, m_adv);
            if (mv[LAT-1]) begin
                chk("out_p", out_p, mp[LAT-1]);
                chk("out_tag", out_tag, mt[LAT-1]);
            end
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_p", out_p, held_p);
                chk("stall_tag", out_tag, held_t);
            end
`ifdef CSA_MULT_CHECK_EN
            chk("chk_err", chk_err, 0);
`endif
            stall_prev = out_valid && !out_ready;
            held_p = out_p;
            held_t = out_tag;
            if (out_valid && out_ready) recv++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [TW-1:0] t);
        logic acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_signed = s;
        in_tag = t;
        do begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(input logic [PW-1:0] ep, input logic [TW-1:0] et,
                            input int elat, input string nm);
        int n;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
        end
        chk({nm, "_valid"}, out_valid, 1);
        if (elat > 0) chk({nm, "_lat"}, 64'(n), 64'(elat));
        chk({nm, "_p"}, out_p, ep);
        chk({nm, "_tag"}, out_tag, et);
    endtask

    task automatic drain(input int target);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (recv < target && n < 2000) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_count", 64'(recv), 64'(target));
        out_ready = 1'b1;
        idle(3);
    endtask

    initial begin
        int base;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        idle(2);

        send(16'h1234, 16'h5678, 1'b0, 4'd3);
        wait_out(32'h0626_0060, 4'd3, LAT, "basic");
        idle(2);

        send(16'hFFFF, 16'hFFFF, 1'b0, 4'd1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 4'd2);
        wait_out(32'hFFFE_0001, 4'd1, -1, "ff_uns");
        @(negedge clk);
        chk("ff_sgn_valid", out_valid, 1);
        chk("ff_sgn_p", out_p, 32'h0000_0001);
        chk("ff_sgn_tag", out_tag, 4'd2);
        idle(LAT + 1);

        send(16'h8000, 16'h8000, 1'b1, 4'd4);
        wait_out(32'h4000_0000, 4'd4, -1, "min_min");
        idle(LAT + 1);
        send(16'h8000, 16'h0001, 1'b1, 4'd5);
        wait_out(32'hFFFF_8000, 4'd5, -1, "min_one");
        idle(LAT + 1);

        base = recv;
        rnd = 1'b1;
        for (int i = 0; i < 20; i++)
            send(16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'(i));
        drain(base + 20);
        rnd = 1'b0;

        out_ready = 1'b0;
        send(16'h0003, 16'h0005, 1'b0, 4'd7);
        send(16'h0011, 16'h0013, 1'b1, 4'd8);
        send(16'h00F0, 16'h000F, 1'b0, 4'd9);
        idle(2);
        @(negedge clk);
        chk("inflight_valid", out_valid, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_p", out_p, 0);
        chk("midrst_tag", out_tag, 0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        idle(LAT + 5);
        chk("post_rst_no_stale", out_valid, 0);

`ifdef CSA_MULT_CHECK_EN
        base = recv;
        rnd = 1'b1;
        for (int i = 0; i < 10000; i++)
            send(16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'(i));
        drain(base + 10000);
        rnd = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
